// File: rtl/multi_channel_command_fifo.sv
// Multi-channel command FIFO: CHANNELS independent queues merged by a round-robin arbiter
// onto one registered valid/ready stream. Define CMDQ_OVERFLOW_FLAG_EN to build sticky overflow flags.
module multi_channel_command_fifo #(
    parameter int CHANNELS     = 4,
    parameter int DEPTH        = 16,
    parameter int WIDTH        = 25,
    parameter int AFULL_THRESH = 14
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [CHANNELS-1:0]                     wr_valid,
    input  logic [CHANNELS*WIDTH-1:0]               wr_data,
    output logic [CHANNELS-1:0]                     wr_ready,
    output logic [CHANNELS-1:0]                     almost_full,
    output logic [CHANNELS*($clog2(DEPTH)+1)-1:0]   level,
    input  logic [CHANNELS-1:0]                     flush,
    output logic                                    out_valid,
    output logic [WIDTH-1:0]                        out_data,
    output logic [$clog2(CHANNELS)-1:0]             out_chan,
    input  logic                                    out_ready,
    output logic [CHANNELS-1:0]                     overflow,
    input  logic                                    err_clear
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(CHANNELS);

    logic [WIDTH-1:0] mem  [CHANNELS][DEPTH];
    logic [PW-1:0]    wptr [CHANNELS];
    logic [PW-1:0]    rptr [CHANNELS];
    logic [LW-1:0]    lvl  [CHANNELS];
    logic [CW-1:0]    last_grant;

    logic                load;
    logic                gnt_found;
    logic [CW-1:0]       gnt_chan;
    logic                grant;
    logic [CHANNELS-1:0] eligible;
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;

    function automatic logic [CW-1:0] rr_index(input logic [CW-1:0] base, input int off);
        int idx;
        idx = (int'(base) + 1 + off) % CHANNELS;
        return CW'(idx);
    endfunction

    // Status flags decode only registered levels, so wr_ready never depends on this cycle's pop.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_status
        assign level[c*LW +: LW] = lvl[c];
        assign wr_ready[c]       = rst_n && (lvl[c] != LW'(DEPTH));
        assign almost_full[c]    = rst_n && (lvl[c] >= LW'(AFULL_THRESH));
        assign eligible[c]       = (lvl[c] != '0) && !flush[c];
    end

    assign load  = !out_valid || out_ready;
    assign grant = load && gnt_found;

    always_comb begin
        gnt_found = 1'b0;
        gnt_chan  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!gnt_found && eligible[rr_index(last_grant, i)]) begin
                gnt_found = 1'b1;
                gnt_chan  = rr_index(last_grant, i);
            end
        end
    end

    always_comb begin
        push = '0;
        pop  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            push[c] = wr_valid[c] && wr_ready[c] && !flush[c];
            pop[c]  = grant && (gnt_chan == CW'(c));
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (push[c]) mem[c][wptr[c]] <= wr_data[c*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wptr[c] <= '0;
                rptr[c] <= '0;
                lvl[c]  <= '0;
            end
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            last_grant <= CW'(CHANNELS - 1);
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (flush[c]) begin
                    wptr[c] <= '0;
                    rptr[c] <= '0;
                    lvl[c]  <= '0;
                end else begin
                    if (push[c]) wptr[c] <= wptr[c] + PW'(1);
                    if (pop[c])  rptr[c] <= rptr[c] + PW'(1);
                    if (push[c] && !pop[c])      lvl[c] <= lvl[c] + LW'(1);
                    else if (!push[c] && pop[c]) lvl[c] <= lvl[c] - LW'(1);
                end
            end
            // output register stage: data/chan only move on a grant, valid follows the load decision
            if (load) begin
                out_valid <= gnt_found;
                if (gnt_found) begin
                    out_data   <= mem[gnt_chan][rptr[gnt_chan]];
                    out_chan   <= gnt_chan;
                    last_grant <= gnt_chan;
                end
            end
        end
    end

`ifdef CMDQ_OVERFLOW_FLAG_EN
    logic [CHANNELS-1:0] ovf_q;

    // A new overflow event in the clearing cycle survives the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) ovf_q <= '0;
        else        ovf_q <= (err_clear ? '0 : ovf_q) | (wr_valid & ~wr_ready);
    end

    assign overflow = ovf_q;
`else
    logic unused_err_clear;
    assign unused_err_clear = err_clear;
    assign overflow         = '0;
`endif

endmodule

// File: tb/tb_multi_channel_command_fifo.sv
// Directed bench for multi_channel_command_fifo: expected commands go into a scoreboard queue,
// a monitor pops and compares on every output handshake; status signals are checked inline.
module tb_multi_channel_command_fifo;

    localparam int CHANNELS     = 4;
    localparam int DEPTH        = 16;
    localparam int WIDTH        = 25;
    localparam int AFULL_THRESH = 14;
    localparam int LW           = $clog2(DEPTH) + 1;
    localparam int CW           = $clog2(CHANNELS);
`ifdef CMDQ_OVERFLOW_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [CHANNELS-1:0]         wr_valid;
    logic [CHANNELS*WIDTH-1:0]   wr_data;
    logic [CHANNELS-1:0]         wr_ready;
    logic [CHANNELS-1:0]         almost_full;
    logic [CHANNELS*LW-1:0]      level;
    logic [CHANNELS-1:0]         flush;
    logic                        out_valid;
    logic [WIDTH-1:0]            out_data;
    logic [CW-1:0]               out_chan;
    logic                        out_ready;
    logic [CHANNELS-1:0]         overflow;
    logic                        err_clear;

    logic [WIDTH-1:0]            wd [CHANNELS];
    logic [CW+WIDTH-1:0]         sb [$];
    int                          checks = 0;
    int                          errors = 0;

    multi_channel_command_fifo #(
        .CHANNELS(CHANNELS), .DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_THRESH(AFULL_THRESH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .almost_full(almost_full), .level(level), .flush(flush), .out_valid(out_valid),
        .out_data(out_data), .out_chan(out_chan), .out_ready(out_ready), .overflow(overflow),
        .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    always_comb begin
        wr_data = '0;
        for (int c = 0; c < CHANNELS; c++) wr_data[c*WIDTH +: WIDTH] = wd[c];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] lvl_of(input int c);
        return level[c*LW +: LW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr_valid = '0; flush = '0; err_clear = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_exp(input int c, input logic [WIDTH-1:0] d);
        sb.push_back({CW'(c), d});
    endtask

    // Monitor: every handshake must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: actual chan=%0d data=0x%0h required=no output",
                             out_chan, out_data);
                end else begin
                    logic [CW+WIDTH-1:0] exp;
                    exp = sb.pop_front();
                    if ({out_chan, out_data} !== exp) begin
                        errors++;
                        $display("FAIL sb_cmd: actual chan=%0d data=0x%0h required chan=%0d data=0x%0h",
                                 out_chan, out_data, exp[CW+WIDTH-1:WIDTH], exp[WIDTH-1:0]);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        for (int c = 0; c < CHANNELS; c++) wd[c] = '0;
        rst_n = 1'b0; wr_valid = '0; flush = '0; err_clear = 1'b0; out_ready = 1'b0;

        // reset state
        tick();
        tick();
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_chan", out_chan, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_almost_full", almost_full, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        tick();
        rst_n = 1'b1;

        // single write, 2-cycle latency
        out_ready = 1'b1;
        wd[2] = 25'h0ABCDEF; wr_valid = 4'b0100; push_exp(2, 25'h0ABCDEF);
        tick();
        wr_valid = '0;
        @(negedge clk);
        check("t1_level_e", lvl_of(2), 1);
        check("t1_valid_e", out_valid, 0);
        tick();
        @(negedge clk);
        check("t1_valid_e1", out_valid, 1);
        check("t1_chan", out_chan, 2);
        check("t1_data", out_data, 25'h0ABCDEF);
        check("t1_level_e1", lvl_of(2), 0);
        tick();
        @(negedge clk);
        check("t1_valid_drop", out_valid, 0);

        // fill channel 0 behind a stalled output register
        do_reset();
        wd[3] = 25'h333; wr_valid = 4'b1000; push_exp(3, 25'h333);
        tick();
        wr_valid = '0;
        tick();
        @(negedge clk);
        check("t2_outreg", out_valid, 1);
        for (int i = 0; i < 16; i++) begin
            wd[0] = 25'h100 + 25'(i); wr_valid = 4'b0001; push_exp(0, wd[0]);
            tick();
            @(negedge clk);
            if (i == 12) check("t2_afull_13", almost_full[0], 0);
            if (i == 13) check("t2_afull_14", almost_full[0], 1);
        end
        check("t2_level_full", lvl_of(0), 16);
        check("t2_wr_ready", wr_ready[0], 0);
        check("t2_afull_16", almost_full[0], 1);
        wd[0] = 25'hDEAD;
        tick();
        wr_valid = '0;
        @(negedge clk);
        check("t2_level_17", lvl_of(0), 16);
        check("t2_overflow", overflow[0], OVF_EN);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        @(negedge clk);
        check("t2_ovf_clear", overflow[0], 0);
        tick();
        out_ready = 1'b1;
        repeat (20) tick();
        @(negedge clk);
        check("t2_drained", lvl_of(0), 0);
        check("t2_idle", out_valid, 0);

        // round-robin fairness, FIFO order, no bubbles
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wd[c] = 25'h0A0000 | 25'(c << 8) | 25'(k);
                push_exp(c, wd[c]);
            end
            wr_valid = 4'hF;
            tick();
        end
        wr_valid = '0;
        @(negedge clk);
        check("t3_first_chan", out_chan, 0);
        check("t3_level0", lvl_of(0), 2);
        check("t3_level1", lvl_of(1), 3);
        tick();
        out_ready = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            cnt += int'(out_valid);
        end
        check("t3_no_bubble", cnt, 12);
        tick();
        @(negedge clk);
        check("t3_idle", out_valid, 0);

        // full channel granted while written: write rejected
        do_reset();
        wd[0] = 25'h0F0; wr_valid = 4'b0001; push_exp(0, 25'h0F0);
        tick();
        wr_valid = '0;
        tick();
        for (int i = 0; i < 16; i++) begin
            wd[1] = 25'h200 + 25'(i); wr_valid = 4'b0010; push_exp(1, wd[1]);
            tick();
        end
        wr_valid = '0;
        @(negedge clk);
        check("t4_level_full", lvl_of(1), 16);
        check("t4_wr_ready", wr_ready[1], 0);
        tick();
        out_ready = 1'b1; wd[1] = 25'hBAD; wr_valid = 4'b0010;
        tick();
        wr_valid = '0;
        @(negedge clk);
        check("t4_level_15", lvl_of(1), 15);
        check("t4_grant_chan", out_chan, 1);
        repeat (20) tick();
        @(negedge clk);
        check("t4_drained", lvl_of(1), 0);

        // flush with concurrent write
        do_reset();
        wd[0] = 25'h0E0; wr_valid = 4'b0001; push_exp(0, 25'h0E0);
        tick();
        wr_valid = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            wd[3] = 25'h300 + 25'(i); wr_valid = 4'b1000;
            tick();
        end
        wr_valid = '0;
        @(negedge clk);
        check("t5_level5", lvl_of(3), 5);
        tick();
        out_ready = 1'b1; flush = 4'b1000; wd[3] = 25'hF1F; wr_valid = 4'b1000;
        tick();
        flush = '0; wr_valid = '0;
        @(negedge clk);
        check("t5_level_flushed", lvl_of(3), 0);
        check("t5_no_grant", out_valid, 0);
        repeat (3) tick();
        @(negedge clk);
        check("t5_stay_idle", out_valid, 0);
        tick();
        wd[3] = 25'h3AA; wr_valid = 4'b1000; push_exp(3, 25'h3AA);
        tick();
        wr_valid = '0;
        tick();
        @(negedge clk);
        check("t5_after_flush", out_data, 25'h3AA);
        tick();

        // mid-stream reset pulse
        do_reset();
        wd[1] = 25'h511; wd[2] = 25'h522; wr_valid = 4'b0110;
        tick();
        wd[1] = 25'h512; wd[2] = 25'h523;
        tick();
        wd[3] = 25'h533; wr_valid = 4'b1000;
        tick();
        wr_valid = '0;
        @(negedge clk);
        check("t6_pre_valid", out_valid, 1);
        check("t6_pre_level2", lvl_of(2), 2);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_wr_ready", wr_ready, 0);
        check("t6_rst_afull", almost_full, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_levels", level, 0);
        check("t6_valid", out_valid, 0);
        tick();
        wd[0] = 25'h600; wd[3] = 25'h633; wr_valid = 4'b1001;
        push_exp(0, 25'h600); push_exp(3, 25'h633);
        out_ready = 1'b1;
        tick();
        wr_valid = '0;
        tick();
        @(negedge clk);
        check("t6_first_grant", out_chan, 0);
        repeat (4) tick();

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_channel_command_fifo.md
# multi_channel_command_fifo

Parametrised successor to the single-channel command FIFO. It holds CHANNELS independent command queues that share one clock, and merges them onto a single registered output stream. Merging uses a round-robin arbiter and a valid/ready handshake. It sits between the per-source command producers and the single command consumer, and adds:

- full-DEPTH storage
- per-channel occupancy, almost-full and flush
- an optional sticky overflow flag

## Interface
- CHANNELS, 4: number of input queues; must be ≥2.
- DEPTH, 16: entries per channel; power of two, ≥2; all DEPTH entries are usable.
- WIDTH, 25: command width in bits.
- AFULL_THRESH, 14: almost_full[c] asserts when level[c] ≥ AFULL_THRESH; range 1..DEPTH.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- wr_valid  in  CHANNELS  per-channel write request.
- wr_data  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- wr_ready  out  CHANNELS  channel c can accept a write; equals rst_n && level[c]!=DEPTH.
- almost_full  out  CHANNELS  per-channel threshold flag.
- level  out  CHANNELS*($clog2(DEPTH)+1)  per-channel occupancy, 0..DEPTH; excludes the output register.
- flush  in  CHANNELS  discard all stored entries of channel c.
- out_valid  out  1  output register holds a command.
- out_data  out  WIDTH  command at the head of the merged stream.
- out_chan  out  $clog2(CHANNELS)  source channel of out_data.
- out_ready  in  1  consumer accepts out_data this cycle.
- overflow  out  CHANNELS  sticky: a write was attempted to a full channel.
- err_clear  in  1  clears all overflow bits.

## Operation
- Each channel has its own storage, read/write pointers of $clog2(DEPTH) bits, and a level counter. Pointers wrap naturally modulo DEPTH.
- Write: an accepted write (wr_valid[c] && wr_ready[c]) stores data at wptr[c] and increments wptr[c].
- Load condition: load = !out_valid || out_ready.
- Grant: when load is true, the arbiter grants the first channel c that has level[c]>0 and flush[c]==0. The search starts at last_grant+1 and wraps. On a grant:
  - the head entry goes into out_data and its channel index into out_chan;
  - out_valid becomes 1;
  - rptr[c] increments;
  - last_grant becomes c.
- If load is true and no channel is eligible, out_valid becomes 0. out_data and out_chan hold their old values.
- If load is false, the output register holds.
- Level update per channel: +1 on accepted write, −1 on grant, unchanged when both happen in the same cycle.
- Write to a full channel is not accepted, even if that channel is granted in the same cycle; wr_ready has no combinational path from the pop.
- Flush:
  - flush[c] resets wptr[c], rptr[c] and level[c] to 0 at the next edge;
  - a write to c in the same cycle is dropped;
  - c is excluded from the grant in that cycle;
  - a command from c already in the output register is unaffected.
- Fairness: with all channels continuously non-empty and out_ready=1, grants rotate 0,1,…,CHANNELS−1,0,…

## Timing
- Reset (rst_n sampled low at an edge) sets:
  - all pointers and levels to 0;
  - out_valid=0, out_data=0, out_chan=0;
  - last_grant=CHANNELS−1, so channel 0 has priority first;
  - overflow=0.
- While rst_n is low, wr_ready=0 and almost_full=0.
- A reset in mid-stream discards all stored and in-flight commands.
- Latency: a write accepted at edge E updates level at E. With the channel and the output register empty, out_valid rises at E+1, so write to output takes 2 cycles.
- Throughput: one command per cycle with out_ready held high.
- almost_full and wr_ready are combinational decodes of registered level.

## Configuration
- CMDQ_OVERFLOW_FLAG_EN defined:
  - overflow[c] sets at the edge after any cycle with wr_valid[c] && !wr_ready[c] while rst_n=1;
  - err_clear clears all bits;
  - a set in the same cycle as err_clear wins.
- CMDQ_OVERFLOW_FLAG_EN undefined: overflow is tied to 0, err_clear is ignored, and no flag registers are built.

## Test plan
- Reset, then one write of 0x0ABCDEF on channel 2 → out_valid=1 two cycles later with out_data=0x0ABCDEF and out_chan=2; level[2] is 1 for one cycle, then 0.
- out_ready=0; write 16 entries to channel 0 (DEPTH=16) → level[0]=16, wr_ready[0]=0, almost_full[0]=1 from level 14. A 17th write is dropped and overflow[0]=1. After err_clear, overflow[0]=0.
- Preload 3 entries in each of 4 channels, then hold out_ready=1 → out_chan sequence is 0,1,2,3 ×3, with every channel in FIFO order and no bubbles.
- Channel 1 full, out_ready=1, grant to channel 1 and wr_valid[1] in the same cycle → the write is rejected and level[1] goes 16→15.
- Channel 3 holds 5 entries; assert flush[3] together with wr_valid[3] → level[3]=0 next cycle, the written data never appears, and channel 3 is not granted that cycle.
- With 4 entries queued and out_valid=1, pulse rst_n low for one edge → all levels 0, out_valid=0, and the next grant goes to channel 0.
